// File: rtl/ascon_perm_engine.sv
// ascon_perm_engine: iterated ASCON v1.2 permutation (p6 / p8 / p12) with optional
// upstream XOR into x0 before the first round and downstream XOR into x1..x4 after
// the last round.
//
// Parameters
//   UNROLL    rounds evaluated per clock (1 or 2)
//   DONE_HOLD 0: done_o is a one-cycle pulse; 1: done_o holds until the next accepted start
//
// Ports
//   clock_i, resetb_i  clock (rising edge) and asynchronous active-low reset
//   start_i            request a run; nrounds_i must be 6, 8 or 12, else err_o pulses
//   state_in_i         320-bit state x0..x4, x0 in the top 64 bits
//   xorup_select_i     XOR data64_i into x0 before the first round
//   xordn_select_i     01: data256_i into x1..x4, 10: data256_i[127:0] into x3||x4
//   abort_i            only with ASCON_PERM_ABORT_EN: cancel a run in progress
//   state_out_o/tag_o  result state and its x3||x4, updated at completion
//   cipher_o           x0 after the upstream XOR, updated at accept
//   busy_o, done_o     run in progress / run complete
//   err_o              one-cycle pulse on a rejected start
//
// Optional feature macro: ASCON_PERM_ABORT_EN adds abort_i.

module ascon_perm_engine #(
  parameter int unsigned UNROLL    = 1,
  parameter int unsigned DONE_HOLD = 0
) (
  input  logic         clock_i,
  input  logic         resetb_i,
  input  logic         start_i,
  input  logic [3:0]   nrounds_i,
  input  logic [319:0] state_in_i,
  input  logic         xorup_select_i,
  input  logic [63:0]  data64_i,
  input  logic [1:0]   xordn_select_i,
  input  logic [255:0] data256_i,
`ifdef ASCON_PERM_ABORT_EN
  input  logic         abort_i,
`endif
  output logic [319:0] state_out_o,
  output logic [63:0]  cipher_o,
  output logic [127:0] tag_o,
  output logic         busy_o,
  output logic         done_o,
  output logic         err_o
);

  if (UNROLL != 1 && UNROLL != 2) begin : g_bad_unroll
    $error("ascon_perm_engine: UNROLL must be 1 or 2");
  end

  // Round index of the final evaluation step in a run.
  localparam logic [3:0] LastRnd = 4'(12 - UNROLL);

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  state_e         st_q, st_d;
  logic [319:0]   x_q, x_d;
  logic [3:0]     rnd_q, rnd_d;
  logic [1:0]     dn_sel_q, dn_sel_d;
  logic [255:0]   dn_data_q, dn_data_d;
  logic [319:0]   out_q, out_d;
  logic [63:0]    cipher_q, cipher_d;
  logic           done_q, done_d;
  logic           err_q, err_d;

  logic [319:0]   rnd_res;
  logic [319:0]   dn_mask;
  logic [319:0]   up_state;
  logic           nr_legal;

  function automatic logic [63:0] ror64(input logic [63:0] v, input int unsigned n);
    return (v >> n) | (v << (64 - n));
  endfunction

  function automatic logic [319:0] ascon_round(input logic [319:0] s, input logic [3:0] idx);
    logic [63:0] x0, x1, x2, x3, x4;
    logic [63:0] t0, t1, t2, t3, t4;
    x0 = s[319:256];
    x1 = s[255:192];
    x2 = s[191:128];
    x3 = s[127:64];
    x4 = s[63:0];
    // Round constant {4'hF - i, i}; for a 4-bit i, 4'hF - i equals ~i.
    x2 = x2 ^ {56'd0, ~idx, idx};
    // Bitsliced 5-bit S-box.
    x0 = x0 ^ x4;
    x4 = x4 ^ x3;
    x2 = x2 ^ x1;
    t0 = ~x0 & x1;
    t1 = ~x1 & x2;
    t2 = ~x2 & x3;
    t3 = ~x3 & x4;
    t4 = ~x4 & x0;
    x0 = x0 ^ t1;
    x1 = x1 ^ t2;
    x2 = x2 ^ t3;
    x3 = x3 ^ t4;
    x4 = x4 ^ t0;
    x1 = x1 ^ x0;
    x0 = x0 ^ x4;
    x3 = x3 ^ x2;
    x2 = ~x2;
    // Linear diffusion.
    x0 = x0 ^ ror64(x0, 19) ^ ror64(x0, 28);
    x1 = x1 ^ ror64(x1, 61) ^ ror64(x1, 39);
    x2 = x2 ^ ror64(x2, 1) ^ ror64(x2, 6);
    x3 = x3 ^ ror64(x3, 10) ^ ror64(x3, 17);
    x4 = x4 ^ ror64(x4, 7) ^ ror64(x4, 41);
    return {x0, x1, x2, x3, x4};
  endfunction

  // UNROLL consecutive rounds starting at rnd_q.
  always_comb begin
    rnd_res = x_q;
    for (int unsigned k = 0; k < UNROLL; k++) begin
      rnd_res = ascon_round(rnd_res, rnd_q + 4'(k));
    end
  end

  always_comb begin
    dn_mask = '0;
    case (dn_sel_q)
      2'b01:   dn_mask[255:0] = dn_data_q;
      2'b10:   dn_mask[127:0] = dn_data_q[127:0];
      default: dn_mask = '0;
    endcase
  end

  assign nr_legal = (nrounds_i == 4'd6) || (nrounds_i == 4'd8) || (nrounds_i == 4'd12);
  assign up_state = state_in_i ^ {(xorup_select_i ? data64_i : 64'd0), 256'd0};

  always_comb begin
    st_d      = st_q;
    x_d       = x_q;
    rnd_d     = rnd_q;
    dn_sel_d  = dn_sel_q;
    dn_data_d = dn_data_q;
    out_d     = out_q;
    cipher_d  = cipher_q;
    done_d    = (DONE_HOLD != 0) ? done_q : 1'b0;
    err_d     = 1'b0;
    unique case (st_q)
      StIdle: begin
        if (start_i) begin
          if (nr_legal) begin
            st_d      = StRun;
            x_d       = up_state;
            cipher_d  = up_state[319:256];
            rnd_d     = 4'd12 - nrounds_i;
            dn_sel_d  = xordn_select_i;
            dn_data_d = data256_i;
            done_d    = 1'b0;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      StRun: begin
`ifdef ASCON_PERM_ABORT_EN
        if (abort_i) begin
          st_d = StIdle;
        end else
`endif
        begin
          x_d   = rnd_res;
          rnd_d = rnd_q + 4'(UNROLL);
          if (rnd_q == LastRnd) begin
            st_d   = StIdle;
            out_d  = rnd_res ^ dn_mask;
            done_d = 1'b1;
          end
        end
      end
      default: st_d = StIdle;
    endcase
  end

  always_ff @(posedge clock_i or negedge resetb_i) begin
    if (!resetb_i) begin
      st_q      <= StIdle;
      x_q       <= '0;
      rnd_q     <= '0;
      dn_sel_q  <= '0;
      dn_data_q <= '0;
      out_q     <= '0;
      cipher_q  <= '0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      st_q      <= st_d;
      x_q       <= x_d;
      rnd_q     <= rnd_d;
      dn_sel_q  <= dn_sel_d;
      dn_data_q <= dn_data_d;
      out_q     <= out_d;
      cipher_q  <= cipher_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  assign state_out_o = out_q;
  assign tag_o       = out_q[127:0];
  assign cipher_o    = cipher_q;
  assign busy_o      = (st_q == StRun);
  assign done_o      = done_q;
  assign err_o       = err_q;

endmodule

// File: tb/tb_ascon_perm_engine.sv
module tb_ascon_perm_engine;

  logic         clk = 1'b0;
  logic         rstn;
  logic         start;
  logic [3:0]   nrounds;
  logic [319:0] state_in;
  logic         xorup;
  logic [63:0]  d64;
  logic [1:0]   xordn;
  logic [255:0] d256;
`ifdef ASCON_PERM_ABORT_EN
  logic         abort;
`endif

  logic [319:0] so1, so2;
  logic [63:0]  cip1, cip2;
  logic [127:0] tag1, tag2;
  logic         busy1, busy2, done1, done2, err1, err2;

  always #5 clk = ~clk;

  ascon_perm_engine #(.UNROLL(1), .DONE_HOLD(0)) u_dut1 (
    .clock_i(clk), .resetb_i(rstn), .start_i(start), .nrounds_i(nrounds),
    .state_in_i(state_in), .xorup_select_i(xorup), .data64_i(d64),
    .xordn_select_i(xordn), .data256_i(d256),
`ifdef ASCON_PERM_ABORT_EN
    .abort_i(abort),
`endif
    .state_out_o(so1), .cipher_o(cip1), .tag_o(tag1),
    .busy_o(busy1), .done_o(done1), .err_o(err1)
  );

  ascon_perm_engine #(.UNROLL(2), .DONE_HOLD(0)) u_dut2 (
    .clock_i(clk), .resetb_i(rstn), .start_i(start), .nrounds_i(nrounds),
    .state_in_i(state_in), .xorup_select_i(xorup), .data64_i(d64),
    .xordn_select_i(xordn), .data256_i(d256),
`ifdef ASCON_PERM_ABORT_EN
    .abort_i(abort),
`endif
    .state_out_o(so2), .cipher_o(cip2), .tag_o(tag2),
    .busy_o(busy2), .done_o(done2), .err_o(err2)
  );

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  int unsigned cyc      = 0;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [319:0] st;
    int unsigned  cyc;
  } exp_t;

  exp_t         q1[$];
  exp_t         q2[$];
  logic [319:0] last_out1 = '0;
  logic [319:0] last_out2 = '0;
  logic [63:0]  last_cip  = '0;

  task automatic check(input string tag, input logic [319:0] got, input logic [319:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference permutation: S-box applied as a 32-entry table over 5-bit columns.
  localparam logic [4:0] SBOX [32] = '{
    5'h04, 5'h0b, 5'h1f, 5'h14, 5'h1a, 5'h15, 5'h09, 5'h02,
    5'h1b, 5'h05, 5'h08, 5'h12, 5'h1d, 5'h03, 5'h06, 5'h1c,
    5'h1e, 5'h13, 5'h07, 5'h0e, 5'h00, 5'h0d, 5'h11, 5'h18,
    5'h10, 5'h0c, 5'h01, 5'h19, 5'h16, 5'h0a, 5'h0f, 5'h17
  };

  function automatic logic [63:0] rotr(input logic [63:0] v, input int n);
    logic [127:0] d;
    d = {v, v} >> n;
    return d[63:0];
  endfunction

  function automatic logic [319:0] model_round(input logic [319:0] s, input int i);
    logic [63:0] x [5];
    logic [63:0] y [5];
    logic [4:0]  c;
    logic [4:0]  o;
    logic [7:0]  rc;
    for (int w = 0; w < 5; w++) x[w] = s[319-64*w -: 64];
    rc = {4'(15 - i), 4'(i)};
    x[2][7:0] = x[2][7:0] ^ rc;
    for (int b = 0; b < 64; b++) begin
      c = {x[0][b], x[1][b], x[2][b], x[3][b], x[4][b]};
      o = SBOX[c];
      for (int w = 0; w < 5; w++) y[w][b] = o[4-w];
    end
    y[0] = y[0] ^ rotr(y[0], 19) ^ rotr(y[0], 28);
    y[1] = y[1] ^ rotr(y[1], 61) ^ rotr(y[1], 39);
    y[2] = y[2] ^ rotr(y[2], 1) ^ rotr(y[2], 6);
    y[3] = y[3] ^ rotr(y[3], 10) ^ rotr(y[3], 17);
    y[4] = y[4] ^ rotr(y[4], 7) ^ rotr(y[4], 41);
    return {y[0], y[1], y[2], y[3], y[4]};
  endfunction

  function automatic logic [319:0] rand320();
    logic [319:0] r;
    for (int k = 0; k < 10; k++) r[32*k +: 32] = $urandom;
    return r;
  endfunction

  // Scoreboard consumer: every done_o pulse must match the oldest pending run.
  always @(negedge clk) begin
    exp_t e;
    if (done1 === 1'b1) begin
      if (q1.size() == 0) check("dut1_spurious_done", {319'd0, done1}, '0);
      else begin
        e = q1.pop_front();
        check("dut1_done_cycle", 320'(cyc), 320'(e.cyc));
        check("dut1_state_out", so1, e.st);
        check("dut1_tag", {192'd0, tag1}, {192'd0, e.st[127:0]});
        last_out1 = e.st;
      end
    end
    if (done2 === 1'b1) begin
      if (q2.size() == 0) check("dut2_spurious_done", {319'd0, done2}, '0);
      else begin
        e = q2.pop_front();
        check("dut2_done_cycle", 320'(cyc), 320'(e.cyc));
        check("dut2_state_out", so2, e.st);
        check("dut2_tag", {192'd0, tag2}, {192'd0, e.st[127:0]});
        last_out2 = e.st;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Called #1 after a rising edge with both instances idle; returns one cycle later.
  task automatic start_run(input int a, input logic [319:0] st, input logic up,
                           input logic [63:0] dd64, input logic [1:0] dsel,
                           input logic [255:0] dd256);
    logic [319:0] s0;
    logic [319:0] res;
    logic [319:0] dm;
    exp_t         e;
    s0 = st;
    if (up) s0[319:256] = s0[319:256] ^ dd64;
    res = s0;
    for (int i = 12 - a; i < 12; i++) res = model_round(res, i);
    dm = '0;
    if (dsel == 2'b01) dm[255:0] = dd256;
    else if (dsel == 2'b10) dm[127:0] = dd256[127:0];
    res = res ^ dm;
    nrounds  = 4'(a);
    state_in = st;
    xorup    = up;
    d64      = dd64;
    xordn    = dsel;
    d256     = dd256;
    start    = 1'b1;
    e.st  = res;
    e.cyc = cyc + a + 1;
    q1.push_back(e);
    e.cyc = cyc + a / 2 + 1;
    q2.push_back(e);
    tick();
    start = 1'b0;
    check("dut1_cipher", {256'd0, cip1}, {256'd0, s0[319:256]});
    check("dut2_cipher", {256'd0, cip2}, {256'd0, s0[319:256]});
    check("dut1_busy_run", {319'd0, busy1}, 320'd1);
    check("dut2_busy_run", {319'd0, busy2}, 320'd1);
    last_cip = s0[319:256];
  endtask

  task automatic wait_drain();
    for (int k = 0; k < 40; k++) begin
      if (q1.size() == 0 && q2.size() == 0) break;
      tick();
    end
    tick();
    check("dut1_pending_runs", 320'(q1.size()), '0);
    check("dut2_pending_runs", 320'(q2.size()), '0);
    q1.delete();
    q2.delete();
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_state1"}, so1, '0);
    check({tag, "_state2"}, so2, '0);
    check({tag, "_cipher1"}, {256'd0, cip1}, '0);
    check({tag, "_cipher2"}, {256'd0, cip2}, '0);
    check({tag, "_tag1"}, {192'd0, tag1}, '0);
    check({tag, "_tag2"}, {192'd0, tag2}, '0);
    check({tag, "_busy1"}, {319'd0, busy1}, '0);
    check({tag, "_busy2"}, {319'd0, busy2}, '0);
    check({tag, "_done1"}, {319'd0, done1}, '0);
    check({tag, "_done2"}, {319'd0, done2}, '0);
  endtask

  localparam logic [319:0] KatState = {64'h80400c0600000000, 64'h8a55114d1cb6a9a2,
                                       64'hbe263d4d7aecaaff, 64'h4ed0ec0b98c529b7,
                                       64'hc8cddf37bcd0284a};
  localparam logic [255:0] KatKey   = {128'd0, 64'h8a55114d1cb6a9a2, 64'hbe263d4d7aecaaff};

  initial begin
    int bad_nr [3];
    bad_nr   = '{7, 0, 15};
    rstn     = 1'b0;
    start    = 1'b0;
    nrounds  = '0;
    state_in = '0;
    xorup    = 1'b0;
    d64      = '0;
    xordn    = '0;
    d256     = '0;
`ifdef ASCON_PERM_ABORT_EN
    abort    = 1'b0;
`endif
    repeat (3) tick();
    check_zero("reset");
    check("reset_err1", {319'd0, err1}, '0);
    rstn = 1'b1;
    tick();

    // p12 known-answer with downstream XOR of the key into x3||x4; a stray start mid-run.
    start_run(12, KatState, 1'b0, 64'd0, 2'b01, KatKey);
    nrounds  = 4'd6;
    state_in = rand320();
    xordn    = 2'b10;
    d256     = rand320()[255:0];
    start    = 1'b1;
    tick();
    start    = 1'b0;
    wait_drain();

    // p6 with upstream XOR.
    start_run(6, KatState, 1'b1, 64'h0123456789abcdef, 2'b00, '0);
    wait_drain();

    // p8 with each remaining downstream mode.
    start_run(8, rand320(), 1'b0, 64'd0, 2'b10, rand320()[255:0]);
    wait_drain();
    start_run(8, rand320(), 1'b1, 64'hfedcba9876543210, 2'b11, rand320()[255:0]);
    wait_drain();

    // Rejected starts leave everything untouched.
    foreach (bad_nr[k]) begin
      nrounds  = 4'(bad_nr[k]);
      state_in = rand320();
      start    = 1'b1;
      tick();
      start    = 1'b0;
      check("bad_nr_err1", {319'd0, err1}, 320'd1);
      check("bad_nr_err2", {319'd0, err2}, 320'd1);
      check("bad_nr_busy1", {319'd0, busy1}, '0);
      check("bad_nr_busy2", {319'd0, busy2}, '0);
      tick();
      check("bad_nr_err1_clear", {319'd0, err1}, '0);
      check("bad_nr_state1", so1, last_out1);
      check("bad_nr_state2", so2, last_out2);
      check("bad_nr_cipher1", {256'd0, cip1}, {256'd0, last_cip});
    end

    // Back-to-back: second start in the cycle done_o rises on the UNROLL=1 instance.
    start_run(12, rand320(), 1'b0, 64'd0, 2'b01, rand320()[255:0]);
    repeat (12) tick();
    check("b2b_done_rise", {319'd0, done1}, 320'd1);
    start_run(6, rand320(), 1'b1, 64'h5555aaaa3333cccc, 2'b10, rand320()[255:0]);
    check("b2b_done_drop", {319'd0, done1}, '0);
    wait_drain();

    // Reset during RUN cycle 5 clears everything and suppresses done_o.
    start_run(12, rand320(), 1'b0, 64'd0, 2'b01, rand320()[255:0]);
    repeat (4) tick();
    rstn = 1'b0;
    #1;
    check_zero("midrun_reset");
    q1.delete();
    q2.delete();
    last_out1 = '0;
    last_out2 = '0;
    last_cip  = '0;
    tick();
    rstn = 1'b1;
    repeat (20) tick();
    check("post_reset_state1", so1, '0);
    start_run(8, rand320(), 1'b0, 64'd0, 2'b10, rand320()[255:0]);
    wait_drain();

`ifdef ASCON_PERM_ABORT_EN
    // Abort in RUN cycle 3: back to IDLE, no done_o, previous tag retained.
    start_run(12, rand320(), 1'b0, 64'd0, 2'b01, rand320()[255:0]);
    tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_busy1", {319'd0, busy1}, '0);
    check("abort_busy2", {319'd0, busy2}, '0);
    q1.delete();
    q2.delete();
    repeat (20) tick();
    check("abort_tag1", {192'd0, tag1}, {192'd0, last_out1[127:0]});
    check("abort_tag2", {192'd0, tag2}, {192'd0, last_out2[127:0]});
`endif

    check("final_busy1", {319'd0, busy1}, '0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ascon_perm_engine.md
ASCON_PERM_ENGINE -- requirements
Module: ascon_perm_engine

Interface
REQ-001 The block SHALL have parameter UNROLL, default 1, rounds computed per clock cycle; legal values 1 or 2 only, elaboration error otherwise.
REQ-002 The block SHALL have parameter DONE_HOLD, default 0; 0 makes done_o a single-cycle pulse, 1 holds done_o until the next accepted start.
REQ-003 clock_i  in  1  sole clock, rising edge.
REQ-004 resetb_i  in  1  asynchronous, active-low reset.
REQ-005 start_i  in  1  request a permutation run.
REQ-006 nrounds_i  in  4  round count a; legal values 6, 8, 12.
REQ-007 state_in_i  in  320 (type_state)  input state x0..x4, x0 most significant.
REQ-008 xorup_select_i  in  1  XOR data64_i into x0 before the first round.
REQ-009 data64_i  in  64  upstream XOR operand.
REQ-010 xordn_select_i  in  2  downstream XOR: 00 none, 01 data256_i into x1..x4, 10 data256_i[127:0] into x3||x4, 11 none.
REQ-011 data256_i  in  256  downstream XOR operand.
REQ-012 state_out_o  out  320 (type_state)  permuted state.
REQ-013 cipher_o  out  64  x0 after the upstream XOR.
REQ-014 tag_o  out  128  x3||x4 of state_out_o.
REQ-015 busy_o  out  1  run in progress.
REQ-016 done_o  out  1  run complete.
REQ-017 err_o  out  1  one-cycle pulse on a rejected start.

Function
REQ-018 The FSM SHALL have two states: IDLE and RUN.
REQ-019 In IDLE with start_i=1 and legal nrounds_i, the block SHALL sample state_in_i, nrounds_i, xordn_select_i, data256_i and apply the upstream XOR; it SHALL load cipher_o and enter RUN next cycle.
REQ-020 Round index SHALL start at 12-a and end at 11; round constant c_i = {4'hF-i, i} SHALL be XORed into the low byte of x2.
REQ-021 Each round SHALL apply constant addition, 5-bit S-box and linear diffusion per the ASCON v1.2 specification.
REQ-022 RUN SHALL last exactly a/UNROLL cycles; UNROLL=2 with a=6, 8 or 12 SHALL take 3, 4 or 6 cycles respectively.
REQ-023 After the last round, the downstream XOR SHALL be applied using the values sampled at start; state_out_o, tag_o and done_o SHALL update in the first IDLE cycle.
REQ-024 busy_o SHALL be 1 exactly while the FSM is in RUN.
REQ-025 While busy, start_i SHALL be ignored; inputs other than start_i SHALL have no effect.
REQ-026 Start with nrounds_i not in {6,8,12} SHALL be rejected: err_o pulses for one cycle, the FSM stays in IDLE, and outputs are unchanged.
REQ-027 Start asserted in the same cycle that done_o rises SHALL be accepted (back-to-back runs); with DONE_HOLD=0, done_o drops on the next cycle.
REQ-028 state_out_o, cipher_o and tag_o SHALL hold their values until the next accepted start (cipher_o) or the next completion (others).

Reset
REQ-029 Asserting resetb_i low SHALL force IDLE immediately and clear all outputs to zero, including mid-run; the interrupted run SHALL produce no done_o.
REQ-030 After reset release, the first accepted start SHALL occur no earlier than the first rising edge with resetb_i=1.

Configuration
REQ-031 Macro ASCON_PERM_ABORT_EN, when defined, SHALL add input abort_i (1 bit); abort_i=1 in RUN returns the FSM to IDLE on the next edge without done_o, leaving state_out_o and tag_o unchanged; abort_i in IDLE has no effect and has priority below start_i.
REQ-032 Without ASCON_PERM_ABORT_EN, port abort_i SHALL NOT exist and a run SHALL always complete.

Verification
REQ-033 UNROLL=1, state_in_i=80400c0600000000_8a55114d1cb6a9a2_be263d4d7aecaaff_4ed0ec0b98c529b7_c8cddf37bcd0284a, a=12, xordn=01, data256_i=0..0_8a55114d1cb6a9a2_be263d4d7aecaaff -> done_o exactly 13 cycles after start; state_out_o equals golden p12 output XOR operand.
REQ-034 Same stimulus with UNROLL=2 -> done_o after 7 cycles and state_out_o bit-identical to REQ-033.
REQ-035 a=6, xorup=1, data64_i=0x0123456789abcdef -> cipher_o = x0 XOR data64_i in the cycle after start; done_o after 7 cycles (UNROLL=1); state_out_o matches golden p6.
REQ-036 nrounds_i=7 with start -> err_o one-cycle pulse, busy_o stays 0, outputs unchanged; start pulsed mid-run -> ignored, run length unchanged.
REQ-037 resetb_i low in RUN cycle 5 -> outputs zero, busy_o 0, no done_o; with ASCON_PERM_ABORT_EN, abort_i in RUN cycle 3 -> IDLE, no done_o, tag_o retains prior value.
